// File: rtl/fft_stage_sequencer_if.sv
// Control bundle between the FFT stage sequencer and its controller/address-generator side.
// The master side issues start/hold; the slave side (the sequencer) returns counter, stage and strobes.
interface fft_stage_sequencer_if #(
    parameter int NUMSTAGES = 5
);
    logic                   start;
    logic                   hold;
    logic [NUMSTAGES-3:0]   counter;
    logic [2:0]             stage_num;
    logic                   rd_en;
    logic                   wr_en;
    logic                   busy;
    logic                   done;

    modport master (
        output start, hold,
        input  counter, stage_num, rd_en, wr_en, busy, done
    );

    modport slave (
        input  start, hold,
        output counter, stage_num, rd_en, wr_en, busy, done
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Steps a radix-2 in-place FFT through stages 0..NUMSTAGES with idle gaps between stages,
// producing the counter/stage pair for the address generator and bank read/write strobes.
module fft_stage_sequencer #(
    parameter int NUMSTAGES  = 5,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    fft_stage_sequencer_if.slave    bus
);
    localparam int CW = NUMSTAGES - 2;
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
    localparam logic [2:0]    LAST_STAGE = 3'(NUMSTAGES);
    localparam logic [3:0]    GAP_LAST   = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  counter_q;
    logic [2:0]     stage_q;
    logic [3:0]     gap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            stage_q   <= '0;
            gap_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    counter_q <= '0;
                    stage_q   <= '0;
                    gap_q     <= '0;
                    if (bus.start) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!bus.hold) begin
                        if (counter_q == CNT_MAX) begin
                            counter_q <= '0;
                            if (stage_q == LAST_STAGE) begin
                                state_q <= S_DONE;
                            end else if (GAP_CYCLES > 0) begin
                                state_q <= S_GAP;
                                gap_q   <= '0;
                            end else begin
                                stage_q <= stage_q + 3'd1;
                            end
                        end else begin
                            counter_q <= counter_q + CW'(1);
                        end
                    end
                end
                S_GAP: begin
                    // Stage number advances only when the pipeline drain window closes.
                    if (!bus.hold) begin
                        if (gap_q == GAP_LAST) begin
                            gap_q   <= '0;
                            stage_q <= stage_q + 3'd1;
                            state_q <= S_RUN;
                        end else begin
                            gap_q <= gap_q + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    counter_q <= '0;
                    stage_q   <= '0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.counter   = counter_q;
    assign bus.stage_num = stage_q;
    assign bus.rd_en     = (state_q == S_RUN) && !bus.hold && (stage_q < LAST_STAGE);
    assign bus.wr_en     = (state_q == S_RUN) && !bus.hold && (stage_q >= 3'd1);
    assign bus.busy      = (state_q == S_RUN) || (state_q == S_GAP);
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: two instances (gap=2 and gap=0) compared every cycle against
// a progress-count model, plus directed latency, hold, reset and start-while-busy scenarios.
module tb_fft_stage_sequencer;
    localparam int N = 5;
    localparam int L = 1 << (N - 2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.NUMSTAGES(N)) bus0 ();
    fft_stage_sequencer_if #(.NUMSTAGES(N)) bus1 ();

    fft_stage_sequencer #(.NUMSTAGES(N), .GAP_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fft_stage_sequencer #(.NUMSTAGES(N), .GAP_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [N-3:0] cnt_a [2];
    logic [2:0]   stg_a [2];
    logic         rd_a  [2];
    logic         wr_a  [2];
    logic         bsy_a [2];
    logic         dn_a  [2];
    assign cnt_a[0] = bus0.counter;   assign cnt_a[1] = bus1.counter;
    assign stg_a[0] = bus0.stage_num; assign stg_a[1] = bus1.stage_num;
    assign rd_a[0]  = bus0.rd_en;     assign rd_a[1]  = bus1.rd_en;
    assign wr_a[0]  = bus0.wr_en;     assign wr_a[1]  = bus1.wr_en;
    assign bsy_a[0] = bus0.busy;      assign bsy_a[1] = bus1.busy;
    assign dn_a[0]  = bus0.done;      assign dn_a[1]  = bus1.done;

    // Model: mode 0=idle, 1=busy, 2=done; p counts unheld busy cycles since start.
    int gap_len [2] = '{2, 0};
    int mode [2];
    int p [2];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_at [2];
    int busy_cnt [2];
    int dn_cnt [2];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare(input logic h);
        for (int k = 0; k < 2; k++) begin
            int ec, es, er, ew, eb, ed, b, w;
            ec = 0; es = 0; er = 0; ew = 0; eb = 0; ed = 0;
            if (mode[k] == 1) begin
                b  = L + gap_len[k];
                es = p[k] / b;
                w  = p[k] % b;
                eb = 1;
                if (w < L) begin
                    ec = w;
                    er = (!h && es < N) ? 1 : 0;
                    ew = (!h && es >= 1) ? 1 : 0;
                end
            end else if (mode[k] == 2) begin
                es = N;
                ed = 1;
            end
            chk($sformatf("dut%0d.counter", k),   int'(cnt_a[k]), ec);
            chk($sformatf("dut%0d.stage_num", k), int'(stg_a[k]), es);
            chk($sformatf("dut%0d.rd_en", k),     int'(rd_a[k]),  er);
            chk($sformatf("dut%0d.wr_en", k),     int'(wr_a[k]),  ew);
            chk($sformatf("dut%0d.busy", k),      int'(bsy_a[k]), eb);
            chk($sformatf("dut%0d.done", k),      int'(dn_a[k]),  ed);
            if (dn_a[k] && done_at[k] < 0) done_at[k] = cyc - start_cyc;
            busy_cnt[k] += int'(bsy_a[k]);
            dn_cnt[k]   += int'(dn_a[k]);
        end
    endtask

    task automatic cycle(input logic s, input logic h);
        @(negedge clk);
        bus0.start = s; bus0.hold = h;
        bus1.start = s; bus1.hold = h;
        #1;
        cyc++;
        compare(h);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            case (mode[k])
                0: if (s) begin mode[k] = 1; p[k] = 0; end
                1: if (!h) begin
                       p[k]++;
                       if (p[k] == (N + 1) * L + N * gap_len[k]) mode[k] = 2;
                   end
                default: mode[k] = 0;
            endcase
        end
    endtask

    task automatic begin_run();
        cycle(1'b1, 1'b0);
        start_cyc = cyc;
        for (int k = 0; k < 2; k++) begin
            done_at[k] = -1; busy_cnt[k] = 0; dn_cnt[k] = 0;
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        bus0.start = 1'b0; bus0.hold = 1'b0;
        bus1.start = 1'b0; bus1.hold = 1'b0;
        mode[0] = 0; mode[1] = 0;
        #1;
        compare(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic nominal_run();
        begin_run();
        repeat (62) cycle(1'b0, 1'b0);
        chk("nominal.done_latency.gap2", done_at[0], 59);
        chk("nominal.done_latency.gap0", done_at[1], 49);
        chk("nominal.busy_cycles.gap2", busy_cnt[0], 58);
        chk("nominal.busy_cycles.gap0", busy_cnt[1], 48);
        chk("nominal.done_pulses.gap2", dn_cnt[0], 1);
        chk("nominal.done_pulses.gap0", dn_cnt[1], 1);
    endtask

    initial begin
        int h1, h2;
        bit sent1, sent2;
        rst = 1'b1;
        mode[0] = 0; mode[1] = 0; p[0] = 0; p[1] = 0;
        bus0.start = 1'b0; bus0.hold = 1'b0;
        bus1.start = 1'b0; bus1.hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare(1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle(1'b0, 1'b0);

        // Nominal transform on both gap settings.
        nominal_run();

        // Hold 3 cycles at stage 2 counter 5, then 2 cycles in the following gap.
        begin_run();
        h1 = 3; h2 = 2;
        for (int i = 0; i < 70; i++) begin
            logic h;
            h = 1'b0;
            if (mode[0] == 1 && p[0] == 2 * (L + 2) + 5 && h1 > 0) begin
                h = 1'b1; h1--;
            end else if (mode[0] == 1 && p[0] == 2 * (L + 2) + L && h2 > 0) begin
                h = 1'b1; h2--;
            end
            cycle(1'b0, h);
        end
        chk("hold.done_latency.gap2", done_at[0], 64);
        chk("hold.done_latency.gap0", done_at[1], 54);
        chk("hold.done_pulses.gap2", dn_cnt[0], 1);

        // Reset during stage 3 aborts the transform silently.
        begin_run();
        while (mode[0] == 1 && p[0] < 3 * (L + 2) + 3) cycle(1'b0, 1'b0);
        async_reset();
        for (int k = 0; k < 2; k++) dn_cnt[k] = 0;
        repeat (20) cycle(1'b0, 1'b0);
        chk("abort.done_pulses.gap2", dn_cnt[0], 0);
        chk("abort.done_pulses.gap0", dn_cnt[1], 0);
        nominal_run();

        // Start pulses during stage 1 and during DONE must be ignored.
        begin_run();
        sent1 = 0; sent2 = 0;
        for (int i = 0; i < 70; i++) begin
            logic s;
            s = 1'b0;
            if (mode[0] == 1 && p[0] == L + 2 + 3 && !sent1) begin s = 1'b1; sent1 = 1; end
            else if (mode[0] == 2 && !sent2) begin s = 1'b1; sent2 = 1; end
            cycle(s, 1'b0);
        end
        chk("busystart.done_pulses.gap2", dn_cnt[0], 1);
        chk("busystart.done_latency.gap2", done_at[0], 59);
        chk("busystart.final_busy.gap2", int'(bsy_a[0]), 0);

        // Randomized start/hold traffic with occasional asynchronous resets.
        async_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            else cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
